// File: rtl/fifo_pkg.sv
// Shared constants and elaboration helpers for the asynchronous FIFO read path.
package fifo_pkg;

  localparam int RAM_LATENCY_MIN = 1;
  localparam int RAM_LATENCY_MAX = 2;

  // The output buffer needs one slot per word that can be in flight plus the head word.
  function automatic int fwft_buf_depth(input int lat);
    return lat + 32'sd1;
  endfunction

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 32'sd0;
    v = value - 32'sd1;
    while (v > 32'sd0) begin
      result = result + 32'sd1;
      v = v / 32'sd2;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_fwft_read_stage_chk.sv
// Protocol and overflow assertions for the FWFT read stage.
module fifo_fwft_read_stage_chk
  import fifo_pkg::*;
#(
  parameter int RAM_LATENCY = 1,
  parameter int BUF_DEPTH   = 2,
  parameter int OCC_W       = 2
) (
  input logic             clk,
  input logic             rst,
  input logic             ctrl_empty,
  input logic             ctrl_inc,
  input logic             ctrl_ram_en,
  input logic             wr_en,
  input logic             buf_full,
  input logic             pop,
  input logic [OCC_W-1:0] occupancy
);

  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(BUF_DEPTH);

  lat_legal: assert property (@(posedge clk)
    (RAM_LATENCY >= RAM_LATENCY_MIN) && (RAM_LATENCY <= RAM_LATENCY_MAX));

  no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(wr_en && buf_full));

  occ_bound: assert property (@(posedge clk) disable iff (rst)
    occupancy <= DEPTH_OCC);

  issue_has_req: assert property (@(posedge clk) disable iff (rst)
    ctrl_ram_en |-> (ctrl_inc && !ctrl_empty));

  pop_has_occ: assert property (@(posedge clk) disable iff (rst)
    pop |-> (occupancy != '0));

endmodule

// File: rtl/fifo_fwft_skid_buf.sv
// Small circular buffer holding words returned by the RAM until the consumer
// takes them; the head entry is always presented on rd_data.
module fifo_fwft_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2,
  localparam int PTR_W     = (clog2(DEPTH) < 32'sd1) ? 32'sd1 : clog2(DEPTH),
  localparam int CNT_W     = clog2(DEPTH + 32'sd1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  pop,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full
);

  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 32'sd1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]      head_r;
  logic [PTR_W-1:0]      tail_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [CNT_W-1:0]      cnt_next_s;
  logic                  pop_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] r;
    if (p == PTR_LAST) begin
      r = '0;
    end else begin
      r = p + PTR_ONE;
    end
    return r;
  endfunction

  assign pop_s   = pop & valid;
  assign valid   = (cnt_r != '0);
  assign full    = (cnt_r == CNT_DEPTH);
  assign rd_data = mem_r[head_r];

  // Word count: a write and a pop in the same cycle cancel out.
  always_comb begin
    cnt_next_s = cnt_r;
    if (wr_en && !pop_s) begin
      cnt_next_s = cnt_r + CNT_ONE;
    end else if (!wr_en && pop_s) begin
      cnt_next_s = cnt_r - CNT_ONE;
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Head/tail pointers and count; both pointers may advance together.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r <= '0;
      tail_r <= '0;
      cnt_r  <= '0;
    end else begin
      cnt_r <= cnt_next_s;
      if (wr_en) begin
        tail_r <= ptr_inc(tail_r);
      end
      if (pop_s) begin
        head_r <= ptr_inc(head_r);
      end
    end
  end

  // Storage array; contents need no reset since visibility is governed by cnt_r.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[tail_r] <= wr_data;
    end
  end

endmodule

// File: rtl/fifo_fwft_read_stage.sv
// FWFT read stage: requests RAM reads while buffer credit exists, tracks reads
// in flight across the RAM latency, and streams returned words out without bubbles.
module fifo_fwft_read_stage
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int RAM_LATENCY = 1,
  localparam int BUF_DEPTH  = fwft_buf_depth(RAM_LATENCY),
  localparam int OCC_W      = clog2(BUF_DEPTH + 32'sd1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ctrl_empty,
  input  logic                  ctrl_ram_en,
  output logic                  ctrl_inc,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [OCC_W-1:0]      occupancy
);

  localparam logic [OCC_W-1:0] BUF_DEPTH_OCC = OCC_W'(BUF_DEPTH);
  localparam logic [OCC_W-1:0] OCC_ONE       = OCC_W'(32'd1);

  logic                   pop_s;
  logic                   wr_en_s;
  logic                   buf_valid_s;
  logic                   buf_full_s;
  logic [RAM_LATENCY-1:0] inflight_r;
  logic [RAM_LATENCY-1:0] inflight_next_s;
  logic [OCC_W-1:0]       occ_r;
  logic [OCC_W-1:0]       occ_next_s;

  assign pop_s     = buf_valid_s & m_ready;
  assign m_valid   = buf_valid_s;
  assign occupancy = occ_r;
  assign wr_en_s   = inflight_r[RAM_LATENCY-1];

  // Read credit: room for another word, or a slot freed by this cycle's pop.
  always_comb begin
    if (rst) begin
      ctrl_inc = 1'b0;
    end else begin
      ctrl_inc = (occ_r < BUF_DEPTH_OCC) | pop_s;
    end
  end

  // Latency pipe: stage 0 records this cycle's issue, last stage marks RAM data valid.
  always_comb begin
    inflight_next_s    = '0;
    inflight_next_s[0] = ctrl_ram_en;
    for (int i = 1; i < RAM_LATENCY; i++) begin
      inflight_next_s[i] = inflight_r[i-1];
    end
  end

  // Credit counter covers both in-flight reads and buffered words.
  always_comb begin
    occ_next_s = occ_r;
    if (ctrl_ram_en && !pop_s) begin
      occ_next_s = occ_r + OCC_ONE;
    end else if (!ctrl_ram_en && pop_s) begin
      occ_next_s = occ_r - OCC_ONE;
    end else begin
      occ_next_s = occ_r;
    end
  end

  // Reset drops in-flight reads so stale RAM output is never captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_r <= '0;
      occ_r      <= '0;
    end else begin
      inflight_r <= inflight_next_s;
      occ_r      <= occ_next_s;
    end
  end

  fifo_fwft_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en_s),
    .wr_data (ram_dout),
    .pop     (pop_s),
    .valid   (buf_valid_s),
    .rd_data (m_data),
    .full    (buf_full_s)
  );

  fifo_fwft_read_stage_chk #(
    .RAM_LATENCY (RAM_LATENCY),
    .BUF_DEPTH   (BUF_DEPTH),
    .OCC_W       (OCC_W)
  ) u_chk (
    .clk         (clk),
    .rst         (rst),
    .ctrl_empty  (ctrl_empty),
    .ctrl_inc    (ctrl_inc),
    .ctrl_ram_en (ctrl_ram_en),
    .wr_en       (wr_en_s),
    .buf_full    (buf_full_s),
    .pop         (pop_s),
    .occupancy   (occ_r)
  );

endmodule

// File: doc/fifo_fwft_read_stage.md
# fifo_fwft_read_stage

Read-side output stage of the asynchronous FIFO. It runs entirely in the read clock domain, directly downstream of the read-mode half controller. It drives the controller's `inc` request, tracks reads actually issued to the dual-port RAM through the controller's `ram_en`, and absorbs the RAM's fixed read latency. It presents a first-word-fall-through valid/ready stream, sustaining one word per cycle with no bubbles.

## Interface
- `DATA_WIDTH`, 32, RAM read-port data width.
- `RAM_LATENCY`, 1, cycles from `ram_en` asserted to data valid on `ram_dout`; legal values 1 or 2.
- `BUF_DEPTH`, derived = `RAM_LATENCY`+1, output buffer entries; not overridable.
- `clk`  in  1  read-domain clock.
- `rst`  in  1  reset; one clock, synchronous, active-high; same net as the read controller's `rst`.
- `ctrl_empty`  in  1  controller `state`; 1 = FIFO empty.
- `ctrl_ram_en`  in  1  controller `ram_en`; 1 = a RAM read was issued this cycle.
- `ctrl_inc`  out  1  read request to the controller `inc`.
- `ram_dout`  in  `DATA_WIDTH`  RAM read data.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  downstream accepts.
- `m_data`  out  `DATA_WIDTH`  output word, head of buffer.
- `occupancy`  out  clog2(`BUF_DEPTH`+1)  reads in flight plus words buffered.

## Operation
- `pop` = `m_valid` & `m_ready`.
- Credit rule: `ctrl_inc` = ~`rst` & ((`occupancy` < `BUF_DEPTH`) | `pop`).
  - Combinational in `m_ready`; there is no other combinational path.
  - Request is held for every cycle credit exists; the controller gates it with empty.
- In-flight tracking: `RAM_LATENCY`-bit shift register; stage 0 loads `ctrl_ram_en`.
  - When the last stage is 1, `ram_dout` is written into the buffer at the tail pointer that cycle.
- Buffer: circular, `BUF_DEPTH` entries, head/tail pointers wrap at `BUF_DEPTH`, stored-word count `cnt`.
  - `m_valid` = (`cnt` != 0). `m_data` = entry[head].
- Counter update: `occupancy` next = `occupancy` + `ctrl_ram_en` − `pop`.
  - Simultaneous issue and pop leave it unchanged.
  - Never exceeds `BUF_DEPTH`; a write arriving to a full buffer is a bug (assert).
- Simultaneous RAM write and pop: both occur; `cnt` unchanged; head and tail both advance.
- `m_data` is stable while `m_valid` & ~`m_ready`; `m_valid` never drops without `pop`.
- Reset values: `m_valid`=0, `ctrl_inc`=0, `occupancy`=0, pointers=0, shift register=0.
  - `m_data` is don't-care.
  - Reset mid-operation discards in-flight and buffered words. The controller's pointers reset together, so no word is double-delivered.

## Timing
- Read issued in cycle T (`ctrl_ram_en`=1).
  - Data captured at the end of cycle T+`RAM_LATENCY`.
  - `m_valid` high in T+`RAM_LATENCY`+1.
- Empty→non-empty: `ctrl_empty` falls in cycle E.
  - Issue occurs in E, since `ctrl_inc` is already high with credit.
  - First `m_valid` in E+`RAM_LATENCY`+1.
- Steady state with `m_ready`=1 and a non-empty FIFO: one word per cycle, `occupancy` = `BUF_DEPTH`−1 or `BUF_DEPTH`.
- `m_ready`=0: issue stops once `occupancy`=`BUF_DEPTH`. Resuming `m_ready` issues in the same cycle as the first pop.
- First cycle after `rst` deasserts: `ctrl_inc`=1, `m_valid`=0.

## Structure
- Shared package `fifo_pkg`:
  - `RAM_LATENCY` legal-range constants.
  - Function `fwft_buf_depth(lat)` = lat+1.
  - Function `clog2`.
- One sub-module, `fifo_fwft_skid_buf`: circular buffer with head/tail/`cnt`, write port plus pop.
  - The top level keeps the credit counter and the latency shift register.

## Test plan
- Single word, `RAM_LATENCY`=1: `ctrl_empty` falls at cycle 10 with `m_ready`=1 → `ctrl_ram_en` at 10, `m_valid` at 12 with the RAM word, `occupancy` returns to 0 at 13.
- Streaming 64 words with `m_ready`=1, `RAM_LATENCY`=2 → 64 consecutive `m_valid` cycles, in-order data 0..63, `occupancy` ≤ 3.
- Backpressure: `m_ready`=0 for 20 cycles mid-stream with `RAM_LATENCY`=1 → `occupancy` saturates at 2, `ctrl_inc`=0, `m_data` stable; release → next word in the same cycle, no loss or duplicate.
- Random `m_ready` (50%) over 1000 words, both latencies → scoreboard exact order, no buffer-overflow assertion fires.
- Wrap-around: more than 2×`BUF_DEPTH` pops with alternating stall → head/tail wrap correctly, data in order.
- Reset with 2 words in flight and 1 buffered → next cycle `m_valid`=0, `occupancy`=0; stale `ram_dout` is not delivered after reset.
